// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: load/store types, FSM states,
// access sizes and the byte-enable helper.
package dmem_responder_pkg;

   typedef enum logic [2:0] {
      LT_NONE = 3'b000,
      LT_LB   = 3'b001,
      LT_LBU  = 3'b010,
      LT_LH   = 3'b011,
      LT_LHU  = 3'b100,
      LT_LW   = 3'b101
   } load_type_e;

   typedef enum logic [1:0] {
      ST_WORD0 = 2'b00,
      ST_BYTE  = 2'b01,
      ST_HALF  = 2'b10,
      ST_WORD  = 2'b11
   } store_type_e;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_NONE} size_e;

   function automatic size_e store_size(input store_type_e st);
      case (st)
         ST_BYTE: store_size = SZ_BYTE;
         ST_HALF: store_size = SZ_HALF;
         default: store_size = SZ_WORD;
      endcase
   endfunction

   function automatic size_e load_size(input load_type_e lt);
      case (lt)
         LT_LB, LT_LBU: load_size = SZ_BYTE;
         LT_LH, LT_LHU: load_size = SZ_HALF;
         LT_LW:         load_size = SZ_WORD;
         default:       load_size = SZ_NONE;
      endcase
   endfunction

   // Low address bits beyond natural alignment are ignored here, which is what
   // gives the masking behaviour when misalignment is not trapped.
   function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] a);
      case (sz)
         SZ_BYTE: byte_en = 4'b0001 << a;
         SZ_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_load_formatter.sv
// Combinational load lane select plus sign/zero extension; unknown load types yield 0.
module dmem_load_formatter
   import dmem_responder_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  load_type_e  load_type,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (load_type)
         LT_LB:   data = {{24{b[7]}}, b};
         LT_LBU:  data = {24'h0, b};
         LT_LH:   data = {{16{h[15]}}, h};
         LT_LHU:  data = {16'h0, h};
         LT_LW:   data = word;
         default: data = 32'h0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, stores commit at accept, loads return
// after LATENCY wait cycles. Define DMEM_MISALIGN_TRAP_EN to error misaligned accesses.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1,
   parameter int WIDTH   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   input  logic [1:0]       req_store_type,
   input  logic [2:0]       req_load_type,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WIDTH-3:0] DEPTH_W = (WIDTH-2)'(DEPTH);

   logic [31:0]   mem [DEPTH];

   state_e        state;
   logic [3:0]    cnt;
   logic [AW-1:0] r_idx;
   logic [1:0]    r_lane;
   load_type_e    r_lt;
   logic          r_err;

   logic          accept, acc_err, wr_en;
   size_e         acc_size;
   logic [3:0]    be;
   logic [31:0]   wdata_rep, fmt_data;
   logic [AW-1:0] idx;

   always_comb begin
      accept   = req_valid && req_ready;
      idx      = req_addr[AW+1:2];
      acc_size = req_we ? store_size(store_type_e'(req_store_type))
                        : load_size(load_type_e'(req_load_type));
      acc_err  = (req_addr[WIDTH-1:2] >= DEPTH_W);
`ifdef DMEM_MISALIGN_TRAP_EN
      if ((acc_size == SZ_HALF && req_addr[0]) ||
          (acc_size == SZ_WORD && req_addr[1:0] != 2'b00))
         acc_err = 1'b1;
`endif
      be = byte_en(acc_size, req_addr[1:0]);
      case (acc_size)
         SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
         SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
         default: wdata_rep = req_wdata;
      endcase
      // The rst term keeps an accept edge coinciding with reset from writing.
      wr_en = accept && req_we && !acc_err && !rst;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
   end

   dmem_load_formatter u_fmt (
      .word      (mem[r_idx]),
      .lane      (r_lane),
      .load_type (r_lt),
      .data      (fmt_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         r_idx     <= '0;
         r_lane    <= 2'b00;
         r_lt      <= LT_NONE;
         r_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               req_ready <= 1'b0;
               if (req_we) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_err   <= acc_err;
               end else begin
                  state  <= WAIT;
                  cnt    <= 4'(LATENCY - 1);
                  r_idx  <= idx;
                  r_lane <= req_addr[1:0];
                  r_lt   <= load_type_e'(req_load_type);
                  r_err  <= acc_err;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= r_err ? 32'h0 : fmt_data;
                  rsp_err   <= r_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: if (rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=1 instance for the main table and
// a LATENCY=4 instance for the reset-during-wait sequence.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst1, rst4;
   logic        req_valid, req_we, rsp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_store_type;
   logic [2:0]  req_load_type;

   logic        rr1, rv1, re1, rr4, rv4, re4;
   logic [31:0] rd1, rd4;
   logic        sel;
   logic        m_req_ready, m_rsp_valid, m_rsp_err;
   logic [31:0] m_rsp_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(1024), .LATENCY(1), .WIDTH(32)) dut (
      .clk(clk), .rst(rst1), .req_valid(req_valid), .req_ready(rr1), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_store_type(req_store_type),
      .req_load_type(req_load_type), .rsp_valid(rv1), .rsp_ready(rsp_ready),
      .rsp_rdata(rd1), .rsp_err(re1));

   dmem_responder #(.DEPTH(1024), .LATENCY(4), .WIDTH(32)) dut4 (
      .clk(clk), .rst(rst4), .req_valid(req_valid), .req_ready(rr4), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_store_type(req_store_type),
      .req_load_type(req_load_type), .rsp_valid(rv4), .rsp_ready(rsp_ready),
      .rsp_rdata(rd4), .rsp_err(re4));

   assign m_req_ready = sel ? rr4 : rr1;
   assign m_rsp_valid = sel ? rv4 : rv1;
   assign m_rsp_rdata = sel ? rd4 : rd1;
   assign m_rsp_err   = sel ? re4 : re1;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  st;
      logic [2:0]  lt;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] st, input logic [2:0] lt,
                               input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.st = st; v.lt = lt;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
      return v;
   endfunction

   // Drive one request with rsp_ready high; lat counts clock edges from the accept
   // edge up to the first edge that sees rsp_valid.
   task automatic do_req(input int idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] st, input logic [2:0] lt,
                         output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      check("req_ready_idle", idx, {31'h0, m_req_ready}, 32'h1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_store_type = st; req_load_type = lt; rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!m_rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rdata = m_rsp_rdata;
      err   = m_rsp_err;
      @(posedge clk);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;

   initial begin
      rst1 = 1'b1; rst4 = 1'b1; sel = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_store_type = 2'b00; req_load_type = 3'b000; rsp_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_req_ready", 0, {31'h0, rr1}, 32'h1);
      check("rst_rsp_valid", 0, {31'h0, rv1}, 32'h0);
      check("rst_rsp_rdata", 0, rd1, 32'h0);
      check("rst_rsp_err",   0, {31'h0, re1}, 32'h0);
      rst1 = 1'b0;

      vecs.push_back(mk(1, 32'h10, 32'hDEADBEEF, 2'b11, 3'b000, 32'h0,        0, 1));
      vecs.push_back(mk(0, 32'h10, 32'h0,        2'b00, 3'b101, 32'hDEADBEEF, 0, 2));
      vecs.push_back(mk(1, 32'h10, 32'h0,        2'b11, 3'b000, 32'h0,        0, 1));
      vecs.push_back(mk(1, 32'h13, 32'h80,       2'b01, 3'b000, 32'h0,        0, 1));
      vecs.push_back(mk(0, 32'h13, 32'h0,        2'b00, 3'b001, 32'hFFFFFF80, 0, 2));
      vecs.push_back(mk(0, 32'h13, 32'h0,        2'b00, 3'b010, 32'h00000080, 0, 2));
      vecs.push_back(mk(0, 32'h10, 32'h0,        2'b00, 3'b101, 32'h80000000, 0, 2));
      vecs.push_back(mk(1, 32'h20, 32'h12345678, 2'b11, 3'b000, 32'h0,        0, 1));
      vecs.push_back(mk(1, 32'h22, 32'h8001,     2'b10, 3'b000, 32'h0,        0, 1));
      vecs.push_back(mk(0, 32'h22, 32'h0,        2'b00, 3'b011, 32'hFFFF8001, 0, 2));
      vecs.push_back(mk(0, 32'h22, 32'h0,        2'b00, 3'b100, 32'h00008001, 0, 2));
      vecs.push_back(mk(0, 32'h20, 32'h0,        2'b00, 3'b101, 32'h80015678, 0, 2));
      vecs.push_back(mk(0, 32'h21, 32'h0,        2'b00, 3'b001, 32'h00000056, 0, 2));
      vecs.push_back(mk(0, 32'h20, 32'h0,        2'b00, 3'b010, 32'h00000078, 0, 2));
      vecs.push_back(mk(0, 32'h20, 32'h0,        2'b00, 3'b000, 32'h0,        0, 2));
      vecs.push_back(mk(0, 32'h20, 32'h0,        2'b00, 3'b111, 32'h0,        0, 2));
      vecs.push_back(mk(1, 32'h0,  32'h11111111, 2'b11, 3'b000, 32'h0,        0, 1));
      vecs.push_back(mk(1, 32'h1000, 32'hFFFFFFFF, 2'b11, 3'b000, 32'h0,      1, 1));
      vecs.push_back(mk(0, 32'h1000, 32'h0,      2'b00, 3'b101, 32'h0,        1, 2));
      vecs.push_back(mk(0, 32'h0,  32'h0,        2'b00, 3'b101, 32'h11111111, 0, 2));
      vecs.push_back(mk(1, 32'h30, 32'h0BADF00D, 2'b00, 3'b000, 32'h0,        0, 1));
      vecs.push_back(mk(0, 32'h30, 32'h0,        2'b00, 3'b101, 32'h0BADF00D, 0, 2));
      vecs.push_back(mk(1, 32'h14, 32'h0,        2'b11, 3'b000, 32'h0,        0, 1));
`ifdef DMEM_MISALIGN_TRAP_EN
      vecs.push_back(mk(0, 32'h12, 32'h0,        2'b00, 3'b101, 32'h0,        1, 2));
      vecs.push_back(mk(1, 32'h16, 32'hAAAAAAAA, 2'b11, 3'b000, 32'h0,        1, 1));
      vecs.push_back(mk(0, 32'h14, 32'h0,        2'b00, 3'b101, 32'h0,        0, 2));
      vecs.push_back(mk(0, 32'h23, 32'h0,        2'b00, 3'b011, 32'h0,        1, 2));
      vecs.push_back(mk(1, 32'h31, 32'h7FFF,     2'b10, 3'b000, 32'h0,        1, 1));
      vecs.push_back(mk(0, 32'h30, 32'h0,        2'b00, 3'b101, 32'h0BADF00D, 0, 2));
`else
      vecs.push_back(mk(0, 32'h12, 32'h0,        2'b00, 3'b101, 32'h80000000, 0, 2));
      vecs.push_back(mk(1, 32'h16, 32'hAAAAAAAA, 2'b11, 3'b000, 32'h0,        0, 1));
      vecs.push_back(mk(0, 32'h14, 32'h0,        2'b00, 3'b101, 32'hAAAAAAAA, 0, 2));
      vecs.push_back(mk(0, 32'h23, 32'h0,        2'b00, 3'b011, 32'hFFFF8001, 0, 2));
      vecs.push_back(mk(1, 32'h31, 32'h7FFF,     2'b10, 3'b000, 32'h0,        0, 1));
      vecs.push_back(mk(0, 32'h30, 32'h0,        2'b00, 3'b101, 32'h0BAD7FFF, 0, 2));
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         do_req(i, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].st, vecs[i].lt, rd, er, lat);
         check("rdata", i, rd, vecs[i].exp_rdata);
         check("err", i, {31'h0, er}, {31'h0, vecs[i].exp_err});
         check("latency", i, lat, vecs[i].exp_lat);
      end

      // Held response: stable outputs, no accept of a store pulse while stalled.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_load_type = 3'b101;
      rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rv1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("stall_latency", 100, lat, 2);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 100 + i, {31'h0, rv1}, 32'h1);
         check("stall_rdata", 100 + i, rd1, 32'h80000000);
         check("stall_ready", 100 + i, {31'h0, rr1}, 32'h0);
         if (i == 2) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
            req_wdata = 32'h55; req_store_type = 2'b11;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("release_valid", 105, {31'h0, rv1}, 32'h0);
      check("release_ready", 105, {31'h0, rr1}, 32'h1);
      do_req(106, 1'b0, 32'h10, 32'h0, 2'b00, 3'b101, rd, er, lat);
      check("stall_ignored_store", 106, rd, 32'h80000000);

      // LATENCY=4 instance: latency, then reset during WAIT.
      sel = 1'b1;
      @(negedge clk);
      rst4 = 1'b0;
      do_req(200, 1'b1, 32'h40, 32'hCAFEF00D, 2'b11, 3'b000, rd, er, lat);
      check("l4_store_lat", 200, lat, 1);
      do_req(201, 1'b0, 32'h40, 32'h0, 2'b00, 3'b101, rd, er, lat);
      check("l4_load_rdata", 201, rd, 32'hCAFEF00D);
      check("l4_load_lat", 201, lat, 5);

      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_load_type = 3'b101;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #2 rst4 = 1'b1;
      #1;
      check("rst_wait_valid", 202, {31'h0, rv4}, 32'h0);
      check("rst_wait_ready", 202, {31'h0, rr4}, 32'h1);
      @(negedge clk);
      rst4 = 1'b0;
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rv4) seen = 1'b1;
         end
         check("rst_wait_no_rsp", 203, {31'h0, seen}, 32'h0);
      end
      do_req(204, 1'b0, 32'h40, 32'h0, 2'b00, 3'b101, rd, er, lat);
      check("post_rst_rdata", 204, rd, 32'hCAFEF00D);
      check("post_rst_err", 204, {31'h0, er}, 32'h0);
      check("post_rst_lat", 204, lat, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
